round_cipher_5r: RTL and testbench

ROUND_CIPHER_5R -- requirements
Module: round_cipher_5r

---
 rtl/round_cipher_5r.sv | 148 ++++++++++++++
 tb/tb_round_cipher_5r.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_cipher_5r.sv
// Five-round ARX block cipher with a shadow/active round-key bank pair.
// One block is in flight at a time: accept, five rounds, whitened output, handshake.
module round_cipher_5r #(
    parameter int ROUND    = 5,
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [KEY_SIZE-1:0] K0,
    input  logic [KEY_SIZE-1:0] K1,
    input  logic [KEY_SIZE-1:0] K2,
    input  logic [KEY_SIZE-1:0] K3,
    input  logic [KEY_SIZE-1:0] K4,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_SIZE-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [KEY_SIZE-1:0] out_data,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam logic [2:0] LAST_ROUND = 3'(ROUND - 1);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          round_q;
    logic                key_loaded;
    logic [KEY_SIZE-1:0] s_q;
    logic [KEY_SIZE-1:0] out_q;
    logic [KEY_SIZE-1:0] port_key   [ROUND];
    logic [KEY_SIZE-1:0] shadow_key [ROUND];
    logic [KEY_SIZE-1:0] active_key [ROUND];
    logic [KEY_SIZE-1:0] round_key;
    logic [KEY_SIZE-1:0] round_out;
    logic                accept;
    logic                last_round;

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] t;
        logic [31:0]  w0, w1, w2, w3;
        logic [31:0]  a, b, c, d;
        t  = s ^ k;
        w3 = t[127:96];
        w2 = t[95:64];
        w1 = t[63:32];
        w0 = t[31:0];
        a  = w0 + w1;
        b  = {w1[24:0], w1[31:25]} ^ a;
        c  = w2 + w3;
        d  = {w3[18:0], w3[31:19]} ^ c;
        return {b, c, d, a};
    endfunction

    assign port_key[0] = K0;
    assign port_key[1] = K1;
    assign port_key[2] = K2;
    assign port_key[3] = K3;
    assign port_key[4] = K4;

    assign in_ready   = (state_q == ST_IDLE) && key_loaded;
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = out_q;
    assign accept     = in_valid && in_ready;
    assign last_round = (round_q == LAST_ROUND);

    always_comb begin
        round_key = '0;
        case (round_q)
            3'd0:    round_key = active_key[0];
            3'd1:    round_key = active_key[1];
            3'd2:    round_key = active_key[2];
            3'd3:    round_key = active_key[3];
            3'd4:    round_key = active_key[4];
            default: round_key = '0;
        endcase
    end

    assign round_out = round_fn(s_q, round_key);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_ROUND;
            ST_ROUND: if (last_round) state_d = ST_DONE;
            ST_DONE:  if (out_ready)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_q <= '0;
            s_q     <= '0;
            out_q   <= '0;
        end else if (accept) begin
            round_q <= '0;
            s_q     <= in_data;
        end else if (state_q == ST_ROUND) begin
            round_q <= last_round ? 3'd0 : round_q + 3'd1;
            s_q     <= round_out;
            if (last_round) begin
                out_q <= round_out ^ active_key[0];
            end
        end
    end

    // The active bank is frozen between accept and handshake, so key updates
    // arriving mid-block only land in the shadow bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_loaded <= 1'b0;
            for (int i = 0; i < ROUND; i++) begin
                shadow_key[i] <= '0;
                active_key[i] <= '0;
            end
        end else begin
            if (key_valid) begin
                key_loaded <= 1'b1;
                for (int i = 0; i < ROUND; i++) begin
                    shadow_key[i] <= port_key[i];
                end
            end
            if (accept) begin
                for (int i = 0; i < ROUND; i++) begin
                    active_key[i] <= key_valid ? port_key[i] : shadow_key[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_round_cipher_5r.sv
// Self-checking bench for round_cipher_5r: a transaction-level reference model
// plus per-cycle output comparison and directed scenarios.
module tb_round_cipher_5r;

    typedef logic [4:0][127:0] key_bank_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    key_bank_t    k_port = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    round_cipher_5r #(.ROUND(5), .KEY_SIZE(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .K0        (k_port[0]),
        .K1        (k_port[1]),
        .K2        (k_port[2]),
        .K3        (k_port[3]),
        .K4        (k_port[4]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl32(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k);
        logic [31:0] w [4];
        logic [31:0] a, b, c, d;
        for (int i = 0; i < 4; i++) w[i] = 32'((s ^ k) >> (32 * i));
        a = w[0] + w[1];
        b = rotl32(w[1], 7) ^ a;
        c = w[2] + w[3];
        d = rotl32(w[3], 13) ^ c;
        return {b, c, d, a};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input key_bank_t keys);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r < 5; r++) s = model_round(s, keys[r]);
        return s ^ keys[0];
    endfunction

    // Transaction-level model: a block is in flight from accept until the
    // handshake; its ciphertext is due once five edges have passed.
    key_bank_t    m_shadow = '0;
    bit           m_key_loaded = 1'b0;
    bit           m_busy = 1'b0;
    int           m_age = 0;
    logic [127:0] m_expect = '0;
    int           cyc = 0;
    int           m_last_accept = 0;
    int           m_spacing = 0;
    int           m_accepts = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_shadow     <= '0;
            m_key_loaded <= 1'b0;
            m_busy       <= 1'b0;
            m_age        <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (m_age >= 5 && out_ready) m_busy <= 1'b0;
                else if (m_age < 5)          m_age  <= m_age + 1;
            end else if (in_valid && m_key_loaded) begin
                m_busy        <= 1'b1;
                m_age         <= 0;
                m_expect      <= model_encrypt(in_data, key_valid ? k_port : m_shadow);
                m_spacing     <= cyc - m_last_accept;
                m_last_accept <= cyc;
                m_accepts     <= m_accepts + 1;
            end
            if (key_valid) begin
                m_shadow     <= k_port;
                m_key_loaded <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_in_ready", 128'(in_ready), 128'(m_key_loaded && !m_busy));
        checkOutput("cyc_out_valid", 128'(out_valid), 128'(m_busy && m_age >= 5));
        checkOutput("cyc_busy", 128'(busy), 128'(m_busy));
        if (m_busy && m_age >= 5) checkOutput("cyc_out_data", out_data, m_expect);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_keys(input key_bank_t keys);
        key_valid = 1'b1;
        k_port    = keys;
        tick(1);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            tick(1);
            n++;
        end
        if (!in_ready) checkOutput("wait_ready_timeout", 128'(in_ready), 128'd1);
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input bit with_keys, input key_bank_t keys);
        wait_ready();
        in_valid = 1'b1;
        in_data  = pt;
        if (with_keys) begin
            key_valid = 1'b1;
            k_port    = keys;
        end
        tick(1);
        in_valid  = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick(1);
            n++;
        end
        if (!out_valid) checkOutput("wait_out_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick(1);
            n++;
        end
        if (busy) checkOutput("wait_idle_timeout", 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        key_bank_t    zero_keys;
        key_bank_t    kb;
        key_bank_t    kn;
        key_bank_t    kc;
        logic [127:0] base;
        logic [127:0] pts [5];
        logic [127:0] held;
        int           n;
        int           bad;
        int           first_accepts;

        zero_keys = '0;
        base = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        for (int i = 0; i < 5; i++) begin
            kb[i] = (base << (32 * i)) | (base >> (128 - 32 * i));
            kn[i] = ~kb[i];
            kc[i] = kb[i] ^ {4{32'h5A5A_0F0F}};
        end
        pts[0] = 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333;
        pts[1] = 128'h11112222_33334444_55556666_77778888;
        pts[2] = 128'h00000000_00000000_00000000_00000000;
        pts[3] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
        pts[4] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        // Hand-computed pins on the reference model.
        checkOutput("pin_round_low", model_round('0, 128'h00000000_00000000_00000001_00000001),
                    128'h00000082_00000000_00000000_00000002);
        checkOutput("pin_round_high", model_round('0, 128'h80000000_00000000_00000000_00000000),
                    128'h00000000_80000000_80001000_00000000);
        checkOutput("pin_zero_block", model_encrypt('0, zero_keys), 128'h0);

        tick(3);
        checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_out_data", out_data, 128'h0);
        reset = 1'b0;
        tick(1);

        $display("[TB] no key loaded: block must be refused");
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        bad = 0;
        repeat (20) begin
            tick(1);
            if (in_ready || out_valid) bad++;
        end
        checkOutput("no_key_refused", 128'(bad), 128'd0);
        in_valid = 1'b0;

        $display("[TB] zero keys, zero block, latency");
        load_keys(zero_keys);
        applyStimulus('0, 1'b0, zero_keys);
        wait_out(n);
        checkOutput("latency", 128'(n), 128'd5);
        checkOutput("zero_ciphertext", out_data, 128'h0);
        wait_idle();

        $display("[TB] five blocks back to back");
        load_keys(kb);
        first_accepts = m_accepts;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_ready();
            in_data = pts[i];
            tick(1);
            in_data = ~pts[i];
            if (i > 0) checkOutput("accept_spacing", 128'(m_spacing), 128'd7);
        end
        in_valid = 1'b0;
        wait_idle();
        checkOutput("accept_count", 128'(m_accepts - first_accepts), 128'd5);

        $display("[TB] output held while out_ready low");
        out_ready = 1'b0;
        applyStimulus(pts[1], 1'b0, zero_keys);
        wait_out(n);
        held = out_data;
        checkOutput("hold_value", held, model_encrypt(pts[1], kb));
        repeat (10) begin
            tick(1);
            checkOutput("hold_out_valid", 128'(out_valid), 128'd1);
            checkOutput("hold_out_data", out_data, held);
            checkOutput("hold_in_ready", 128'(in_ready), 128'd0);
            checkOutput("hold_busy", 128'(busy), 128'd1);
        end
        out_ready = 1'b1;
        wait_idle();

        $display("[TB] key update mid-block and coincident with accept");
        applyStimulus(pts[0], 1'b0, zero_keys);
        tick(2);
        load_keys(kn);
        wait_out(n);
        checkOutput("midblock_old_keys", out_data, model_encrypt(pts[0], kb));
        wait_idle();
        applyStimulus(pts[0], 1'b0, zero_keys);
        wait_out(n);
        checkOutput("next_block_new_keys", out_data, model_encrypt(pts[0], kn));
        wait_idle();
        applyStimulus(pts[4], 1'b1, kc);
        wait_out(n);
        checkOutput("bypass_port_keys", out_data, model_encrypt(pts[4], kc));
        wait_idle();

        $display("[TB] reset mid-block aborts");
        applyStimulus(pts[3], 1'b0, zero_keys);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_out_data", out_data, 128'h0);
        in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            tick(1);
            if (in_ready || out_valid || busy) bad++;
        end
        checkOutput("abort_needs_key", 128'(bad), 128'd0);
        in_valid = 1'b0;
        load_keys(kb);
        applyStimulus(pts[2], 1'b0, zero_keys);
        wait_out(n);
        checkOutput("after_abort_block", out_data, model_encrypt(pts[2], kb));
        wait_idle();

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
